// File: rtl/stn_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stn_pkg : types and widths shared by the STN capture stage and framebuffer
// Rev 1.0
// ----------------------------------------------------------------------------
package stn_pkg;

  localparam int FB_Y_W     = 9;
  localparam int FB_X_W     = 10;
  localparam int STN_DATA_W = 4;
  localparam int PX_PER_CP  = 4;
  localparam int PX_W       = 11;
  localparam int LN_W       = 10;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } stn_state_e;

  localparam logic [PX_W-1:0] PX_SAT_AT = PX_W'(2**PX_W - 1 - PX_PER_CP);

  // Advance the pixel counter by one CP worth of pixels, sticking at all-ones.
  function automatic logic [PX_W-1:0] px_step(input logic [PX_W-1:0] px);
    return (px > PX_SAT_AT) ? '1 : px + PX_W'(PX_PER_CP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stn_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stn_sync_edge : 2-flop synchroniser with optional third stage for fall detect
// Rev 1.0
// ----------------------------------------------------------------------------
module stn_sync_edge #(
  parameter int WIDTH      = 1,
  parameter bit EDGE_STAGE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

  generate
    if (EDGE_STAGE) begin : g_edge
      logic [WIDTH-1:0] s3;

      // Cleared to 0 so a line idling high after reset never looks like a fall.
      always_ff @(posedge clk) begin
        if (!rst_n) s3 <= '0;
        else        s3 <= s2;
      end

      assign fall = s3 & ~s2;
    end else begin : g_no_edge
      assign fall = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/stn_capture.sv
`default_nettype none
// ----------------------------------------------------------------------------
// stn_capture : STN panel bus to framebuffer write capture with geometry lock
// Rev 1.0
// ----------------------------------------------------------------------------
module stn_capture
  import stn_pkg::*;
#(
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  stn_flm,
  input  logic                  stn_lp,
  input  logic                  stn_cp,
  input  logic [STN_DATA_W-1:0] stn_data,
  output logic                  fb_we,
  output logic [FB_Y_W-1:0]     fb_y,
  output logic [FB_X_W-1:0]     fb_x,
  output logic [STN_DATA_W-1:0] fb_data,
  output logic [LN_W-1:0]       frame_lines,
  output logic [PX_W-1:0]       line_pixels,
  output logic                  locked
);

  localparam logic [PX_W-1:0] PX_LIMIT  = PX_W'(H_PIXELS);
  localparam logic [LN_W-1:0] LN_LIMIT  = LN_W'(V_LINES);
  localparam logic [3:0]      LOCK_NEED = 4'(LOCK_FRAMES);

  logic                  cp_fall;
  logic                  lp_fall;
  logic                  cp_s2;
  logic                  lp_s2;
  logic                  flm_s2;
  logic [STN_DATA_W-1:0] data_s2;
  logic                  unused_flm_fall;
  logic [STN_DATA_W-1:0] unused_data_fall;
  logic                  unused_lvl;

  stn_sync_edge #(.WIDTH(1), .EDGE_STAGE(1'b1)) u_sync_cp (
    .clk(in_clk), .rst_n(in_rst_n), .d(stn_cp), .q(cp_s2), .fall(cp_fall)
  );
  stn_sync_edge #(.WIDTH(1), .EDGE_STAGE(1'b1)) u_sync_lp (
    .clk(in_clk), .rst_n(in_rst_n), .d(stn_lp), .q(lp_s2), .fall(lp_fall)
  );
  stn_sync_edge #(.WIDTH(1), .EDGE_STAGE(1'b0)) u_sync_flm (
    .clk(in_clk), .rst_n(in_rst_n), .d(stn_flm), .q(flm_s2), .fall(unused_flm_fall)
  );
  stn_sync_edge #(.WIDTH(STN_DATA_W), .EDGE_STAGE(1'b0)) u_sync_data (
    .clk(in_clk), .rst_n(in_rst_n), .d(stn_data), .q(data_s2), .fall(unused_data_fall)
  );

  assign unused_lvl = cp_s2 ^ lp_s2;

  logic [PX_W-1:0] px;
  logic [LN_W-1:0] ln;
  logic [PX_W-1:0] px_cp;
  logic [LN_W-1:0] ln_inc;
  logic            frame_start;

  // A CP fall coinciding with LP is counted before the line is closed.
  assign px_cp       = cp_fall ? px_step(px) : px;
  assign ln_inc      = (ln == '1) ? ln : ln + LN_W'(1);
  assign frame_start = lp_fall & flm_s2;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      px          <= '0;
      ln          <= '0;
      frame_lines <= '0;
      line_pixels <= '0;
    end else if (lp_fall) begin
      line_pixels <= px_cp;
      px          <= '0;
      if (flm_s2) begin
        frame_lines <= ln;
        ln          <= '0;
      end else begin
        ln <= ln_inc;
      end
    end else if (cp_fall) begin
      px <= px_step(px);
    end
  end

  stn_state_e      state;
  stn_state_e      state_n;
  logic [LN_W-1:0] ref_lines;
  logic [LN_W-1:0] ref_lines_n;
  logic [PX_W-1:0] ref_pixels;
  logic [PX_W-1:0] ref_pixels_n;
  logic [3:0]      match_cnt;
  logic [3:0]      match_cnt_n;
  logic [3:0]      cnt_inc;
  logic            geom_match;
  logic            write_ok;

  assign geom_match = (ln == ref_lines) && (px_cp == ref_pixels);
  assign cnt_inc    = match_cnt + 4'd1;

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state      <= UNLOCKED;
      ref_lines  <= '0;
      ref_pixels <= '0;
      match_cnt  <= '0;
    end else begin
      state      <= state_n;
      ref_lines  <= ref_lines_n;
      ref_pixels <= ref_pixels_n;
      match_cnt  <= match_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    ref_lines_n  = ref_lines;
    ref_pixels_n = ref_pixels;
    match_cnt_n  = match_cnt;
    if (frame_start) begin
      case (state)
        UNLOCKED: begin
          state_n      = ACQUIRE;
          ref_lines_n  = ln;
          ref_pixels_n = px_cp;
          match_cnt_n  = 4'd1;
        end
        ACQUIRE: begin
          if (geom_match) begin
            match_cnt_n = cnt_inc;
            if (cnt_inc >= LOCK_NEED) state_n = LOCKED;
          end else begin
            ref_lines_n  = ln;
            ref_pixels_n = px_cp;
            match_cnt_n  = 4'd1;
          end
        end
        LOCKED: begin
          if (!geom_match) begin
            state_n      = ACQUIRE;
            ref_lines_n  = ln;
            ref_pixels_n = px_cp;
            match_cnt_n  = 4'd1;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    write_ok = (state == ACQUIRE) || (state == LOCKED);
    locked   = (state == LOCKED);
  end

  // Two register stages after the detected fall give the fixed bus-to-strobe latency.
  logic                  wr_req;
  logic                  pend_we;
  logic [FB_Y_W-1:0]     pend_y;
  logic [FB_X_W-1:0]     pend_x;
  logic [STN_DATA_W-1:0] pend_d;

  assign wr_req = write_ok && cp_fall && (px < PX_LIMIT) && (ln < LN_LIMIT);

  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      pend_we <= 1'b0;
      pend_y  <= '0;
      pend_x  <= '0;
      pend_d  <= '0;
      fb_we   <= 1'b0;
      fb_y    <= '0;
      fb_x    <= '0;
      fb_data <= '0;
    end else begin
      pend_we <= wr_req;
      if (wr_req) begin
        pend_y <= ln[FB_Y_W-1:0];
        pend_x <= px[FB_X_W-1:0];
        pend_d <= data_s2;
      end
      fb_we <= pend_we;
      if (pend_we) begin
        fb_y    <= pend_y;
        fb_x    <= pend_x;
        fb_data <= pend_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stn_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_stn_capture : directed bench for stn_capture on a scaled 16x4 panel
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_stn_capture;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int LF = 2;
  localparam int NCP = H / 4;

  logic        in_clk   = 1'b0;
  logic        in_rst_n = 1'b0;
  logic        stn_flm  = 1'b0;
  logic        stn_lp   = 1'b0;
  logic        stn_cp   = 1'b1;
  logic [3:0]  stn_data = 4'h0;
  logic        fb_we;
  logic [8:0]  fb_y;
  logic [9:0]  fb_x;
  logic [3:0]  fb_data;
  logic [9:0]  frame_lines;
  logic [10:0] line_pixels;
  logic        locked;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr     = 0;
  int          n0;
  logic        exp_en   = 1'b0;
  logic [22:0] exp_q[$];
  logic [22:0] mon_e;

  stn_capture #(.H_PIXELS(H), .V_LINES(V), .LOCK_FRAMES(LF)) dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .stn_flm(stn_flm), .stn_lp(stn_lp),
    .stn_cp(stn_cp), .stn_data(stn_data), .fb_we(fb_we), .fb_y(fb_y), .fb_x(fb_x),
    .fb_data(fb_data), .frame_lines(frame_lines), .line_pixels(line_pixels),
    .locked(locked)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] pix(int row, int col);
    return 4'((row * 5 + col * 3 + 1) % 16);
  endfunction

  // Every strobe must match the oldest outstanding expected write.
  always @(negedge in_clk) begin
    if (fb_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_yxd", {9'b0, fb_y, fb_x, fb_data}, {9'b0, mon_e});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic cp_pulse(input int row, input int col, input bit with_lp);
    if (with_lp) begin
      stn_lp = 1'b1;
      cyc(2);
    end
    stn_data = pix(row, col);
    stn_cp   = 1'b0;
    if (with_lp) stn_lp = 1'b0;
    if (exp_en && (col * 4 < H) && (row < V))
      exp_q.push_back({9'(row), 10'(col * 4), pix(row, col)});
    cyc(2);
    stn_cp = 1'b1;
    cyc(2);
  endtask

  task automatic lp_pulse(input bit flm);
    stn_flm = flm;
    stn_lp  = 1'b1;
    cyc(2);
    stn_lp  = 1'b0;
    cyc(2);
    stn_flm = 1'b0;
    cyc(4);
  endtask

  // Rows 0..nlines-1 end in LP; a trailing row leaves ln = nlines, px = ncp*4.
  task automatic frame_body(input int nlines, input int ncp, input bit merge);
    for (int r = 0; r <= nlines; r++) begin
      for (int c = 0; c < ncp; c++)
        cp_pulse(r, c, merge && (c == ncp - 1) && (r < nlines));
      if (r < nlines) begin
        if (merge) cyc(2);
        else       lp_pulse(1'b0);
      end
    end
  endtask

  initial begin
    cyc(5);
    check("rst_we", fb_we, 0);
    check("rst_xyd", {fb_y, fb_x, fb_data}, 0);
    check("rst_geom", {frame_lines, line_pixels}, 0);
    check("rst_locked", locked, 0);
    in_rst_n = 1'b1;
    cyc(2);

    // Idle bus: CP only
    for (int c = 0; c < 8; c++) cp_pulse(0, c, 1'b0);
    cyc(4);
    check("idle_locked", locked, 0);
    check("idle_geom", {frame_lines, line_pixels}, 0);
    check("idle_we", fb_we, 0);

    lp_pulse(1'b1);
    exp_en = 1'b1;

    // Single CP latency
    n0 = n_wr;
    stn_data = 4'hA;
    stn_cp   = 1'b0;
    exp_q.push_back({9'd0, 10'd0, 4'hA});
    @(posedge in_clk);
    @(posedge in_clk);
    @(posedge in_clk);
    #1 check("lat_e2_we", fb_we, 0);
    @(posedge in_clk);
    #1 check("lat_e3_we", fb_we, 1);
    check("lat_e3_data", fb_data, 4'hA);
    @(posedge in_clk);
    #1 check("lat_e4_we", fb_we, 0);
    check("lat_hold_data", fb_data, 4'hA);
    cyc(1);
    stn_cp = 1'b1;
    cyc(6);
    check("lat_count", n_wr - n0, 1);

    // Nominal frames
    lp_pulse(1'b1);
    check("f1_start_locked", locked, 0);
    n0 = n_wr;
    frame_body(V, NCP, 1'b0);
    lp_pulse(1'b1);
    check("f2_frame_lines", frame_lines, V);
    check("f2_line_pixels", line_pixels, H);
    check("f2_locked", locked, 0);
    check("f1_strobes", n_wr - n0, V * NCP);
    frame_body(V, NCP, 1'b0);
    lp_pulse(1'b1);
    check("f3_locked", locked, 1);

    // CP and LP falling together on the last pixel of each line
    frame_body(V, NCP, 1'b1);
    lp_pulse(1'b1);
    check("merge_locked", locked, 1);
    check("merge_line_pixels", line_pixels, H);
    check("merge_frame_lines", frame_lines, V);

    // Short frame while locked, then relock
    frame_body(V - 1, NCP, 1'b0);
    lp_pulse(1'b1);
    check("short_locked", locked, 0);
    check("short_frame_lines", frame_lines, V - 1);
    frame_body(V, NCP, 1'b0);
    lp_pulse(1'b1);
    check("relock1_locked", locked, 0);
    frame_body(V, NCP, 1'b0);
    lp_pulse(1'b1);
    check("relock2_locked", locked, 1);

    // Oversized frame: writes clipped to H x V
    frame_body(V + 2, NCP + 2, 1'b0);
    lp_pulse(1'b1);
    check("big_frame_lines", frame_lines, V + 2);
    check("big_line_pixels", line_pixels, H + 8);
    check("big_locked", locked, 0);

    // Reset mid-line
    cp_pulse(0, 0, 1'b0);
    cp_pulse(0, 1, 1'b0);
    cyc(6);
    in_rst_n = 1'b0;
    exp_en   = 1'b0;
    cyc(3);
    check("mid_rst_we", fb_we, 0);
    in_rst_n = 1'b1;
    cyc(1);
    check("post_rst_we", fb_we, 0);
    check("post_rst_locked", locked, 0);
    check("post_rst_geom", {frame_lines, line_pixels}, 0);
    cp_pulse(0, 2, 1'b0);
    cp_pulse(0, 3, 1'b0);
    cyc(4);
    lp_pulse(1'b1);
    exp_en = 1'b1;
    n0 = n_wr;
    frame_body(V, NCP, 1'b0);
    lp_pulse(1'b1);
    check("post_rst_strobes", n_wr - n0, V * NCP);
    check("post_rst_frame_lines", frame_lines, V);

    cyc(6);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stn_capture.md
Name: stn_capture

Overview:
- Front-end capture stage that samples the raw STN panel bus (FLM, LP, CP, 4-bit data) in the capture clock domain.
- Converts the bus into framebuffer write transactions: 9-bit line, 10-bit pixel column, and a 4-pixel nibble.
- Sits directly upstream of the framebuffer input side and drives its y/x/data write port.
- Also tracks frame geometry and reports whether the incoming stream is stable (locked).

Parameters:
- H_PIXELS, 640: active pixels per line. Writes with fb_x >= H_PIXELS are suppressed. Must be a multiple of 4 and <= 1024.
- V_LINES, 480: active lines per frame. Writes with fb_y >= V_LINES are suppressed. Must be <= 512.
- LOCK_FRAMES, 2: number of consecutive frames with identical line count and identical line length required to assert locked. Range 1..15.

Ports:
- in_clk  input  1: capture clock, >= 4x the STN CP frequency.
- in_rst_n  input  1: synchronous, active-low reset, sampled on the rising edge of in_clk.
- stn_flm  input  1: first-line marker (asynchronous).
- stn_lp  input  1: line pulse / latch (asynchronous).
- stn_cp  input  1: pixel shift clock (asynchronous). Data is valid on its falling edge.
- stn_data  input  4: 4 pixels per CP (asynchronous).
- fb_we  output  1: one-cycle write strobe.
- fb_y  output  9: line of the current write.
- fb_x  output  10: column of the first pixel of the nibble; always a multiple of 4.
- fb_data  output  4: pixel nibble.
- frame_lines  output  10: LP count of the last completed frame, saturating at 1023.
- line_pixels  output  11: pixel count of the last completed line, saturating at 2047.
- locked  output  1: geometry stable.

Behaviour:
Reset:
- When in_rst_n is low at a clock edge, all outputs go to 0.
- Synchronisers, counters and the lock counter clear.
- FSM enters UNLOCKED.
- Reset applied mid-line discards any partial line; no fb_we is issued during or in the cycle after reset.

Input synchronisation and edge detection:
- All stn_* inputs pass through 2 flops (s1, s2); CP and LP get a third flop (s3) for edge detection.
- cp_fall = s3 & ~s2; lp_fall = s3 & ~s2 on the LP chain; fields are taken from s2.
- Latency: fb_we asserts exactly 3 in_clk cycles after the first in_clk edge that samples stn_cp low.

Counters (pixel counter px 11-bit, line counter ln 10-bit, both saturating):
- On cp_fall: capture nibble at (ln, px); then px <= px+4.
- On lp_fall with flm_s2 = 1 (frame start):
  - frame_lines <= ln, line_pixels <= px;
  - ln <= 0, px <= 0;
  - run the lock evaluation.
- On lp_fall with flm_s2 = 0: line_pixels <= px, ln <= ln+1, px <= 0.
- cp_fall and lp_fall in the same cycle: the pixel is written with the pre-update coordinates first, then the counter update applies. The nibble is never dropped.

Write rule:
- fb_we = 1 for one cycle only when the state is LOCKED or ACQUIRE, cp_fall occurred, px < H_PIXELS, and ln < V_LINES.
- fb_x = px[9:0], fb_y = ln[8:0], fb_data = data s2 captured on cp_fall.
- fb_x, fb_y and fb_data hold their values between strobes.

FSM (3 states):
- UNLOCKED: no writes. First frame start moves to ACQUIRE, records the reference geometry, and sets match_cnt = 1.
- ACQUIRE: writes enabled. At each frame start:
  - geometry equals the reference: match_cnt++; when match_cnt reaches LOCK_FRAMES, go to LOCKED and set locked = 1;
  - geometry differs: reload the reference and set match_cnt = 1.
- LOCKED: at each frame start, a geometry mismatch returns to ACQUIRE with match_cnt = 1 and locked <= 0 in the same cycle.
- Geometry equality compares both frame_lines and line_pixels.

Overflow:
- ln or px counting beyond its range saturates; writes are already suppressed by the V_LINES / H_PIXELS limits.
- A missing FLM therefore causes no address wrap; ln holds at 1023 until the next frame start.

Decomposition:
- Package stn_pkg holds:
  - the FSM enum (UNLOCKED, ACQUIRE, LOCKED);
  - widths FB_Y_W = 9, FB_X_W = 10, STN_DATA_W = 4, PX_PER_CP = 4.
- These are shared with the framebuffer.
- One sub-module, stn_sync_edge: a parameterised-width 2-flop synchroniser with an optional third stage and falling-edge output. It is instantiated for CP, LP, FLM and data.

Test Plan:
1. Reset then idle bus: hold in_rst_n = 0 for 5 cycles, then toggle CP with no LP/FLM -> fb_we stays 0, locked = 0, all outputs 0.
2. Nominal 640x480 stream with LOCK_FRAMES = 2:
   - writes start in frame 1 at fb_y = 0, fb_x = 0, 4, …, 636;
   - 160 strobes per line;
   - frame_lines = 480, line_pixels = 640 after frame 1;
   - locked rises at the start of frame 3.
3. Latency/edge check: single CP falling edge with data = 4'hA -> fb_we exactly 3 in_clk later with fb_data = 4'hA; no second strobe.
4. CP fall and LP fall in the same cycle on the last pixel (px = 636) -> write at fb_x = 636 on the old line, then next write at fb_x = 0 with fb_y + 1.
5. Geometry change while LOCKED (next frame has 479 lines) -> at that frame start locked = 0, frame_lines = 479, writes continue; relock after 2 more matching frames.
6. Bounds and reset: 800-pixel lines / 600-line frames -> no fb_we for x >= 640 or y >= 480. Assert in_rst_n = 0 mid-line -> no strobe until a new FLM, and state returns to UNLOCKED.
